// File: rtl/screen_pkg.sv
// Shared types and helpers for the screen fade sequencer.
package screen_pkg;

  typedef enum logic [1:0] {
    Start = 2'd0,
    Game  = 2'd1,
    Over  = 2'd2
  } screen_t;

  typedef enum logic [1:0] {
    StShow    = 2'd0,
    StFadeOut = 2'd1,
    StFadeIn  = 2'd2
  } fade_state_t;

  localparam logic [4:0] LEVEL_MAX = 5'd16;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // (c * level) >> 4 with a 9-bit product; level 16 is identity.
  function automatic logic [3:0] scale_chan(input logic [3:0] c, input logic [4:0] level);
    logic [8:0] prod;
    prod = 9'(c) * 9'(level);
    return 4'(prod >> 4);
  endfunction

endpackage

// File: rtl/rgb_scaler.sv
// Combinational brightness scaler for one 12-bit {r,g,b} colour.
module rgb_scaler
  import screen_pkg::*;
(
  input  logic [11:0] i_rgb,
  input  logic [4:0]  i_level,
  output logic [11:0] o_rgb
);

  rgb12_t w_in;
  rgb12_t w_out;

  assign w_in    = rgb12_t'(i_rgb);
  assign w_out.r = scale_chan(w_in.r, i_level);
  assign w_out.g = scale_chan(w_in.g, i_level);
  assign w_out.b = scale_chan(w_in.b, i_level);
  assign o_rgb   = w_out;

endmodule

// File: rtl/screen_fade_sequencer.sv
// Background screen selector with frame-synchronous fade transitions.
// Define SCREEN_FADE_EN for the fade scaler; otherwise screens cut on the next frame_start.
module screen_fade_sequencer
  import screen_pkg::*;
#(
  parameter int unsigned STEP_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        start_btn,
  input  logic        game_over,
  input  logic        blank,
  input  logic [11:0] start_rgb,
  input  logic [11:0] game_rgb,
  input  logic [11:0] over_rgb,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic [1:0]  screen,
  output logic        busy,
  output logic        game_run
);

  // A zero step count is meaningless; such a build never leaves SHOW.
  localparam bit StepOk = (STEP_FRAMES >= 1);

  fade_state_t r_state, w_state_nxt;
  screen_t     r_screen, w_screen_nxt;
  screen_t     r_target, w_target_nxt;
  rgb12_t      r_pix;
  logic        r_busy;
  logic        r_game_run;

  logic        w_accept;
  screen_t     w_req_target;
  logic [11:0] w_sel;
  logic [11:0] w_scaled;

  always_comb begin
    w_accept     = 1'b0;
    w_req_target = r_target;
    if (StepOk && r_state == StShow) begin
      unique case (r_screen)
        Start: if (start_btn) begin w_accept = 1'b1; w_req_target = Game;  end
        Game:  if (game_over) begin w_accept = 1'b1; w_req_target = Over;  end
        Over:  if (start_btn) begin w_accept = 1'b1; w_req_target = Start; end
        default: ;
      endcase
    end
  end

  always_comb begin
    unique case (r_screen)
      Game:    w_sel = game_rgb;
      Over:    w_sel = over_rgb;
      default: w_sel = start_rgb;
    endcase
  end

`ifdef SCREEN_FADE_EN
  localparam int unsigned StepW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

  logic [4:0]       r_level, w_level_nxt;
  logic [StepW-1:0] r_step, w_step_nxt;
  logic             w_step_last;

  assign w_step_last = (r_step == StepW'(STEP_FRAMES - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_screen_nxt = r_screen;
    w_target_nxt = r_target;
    w_level_nxt  = r_level;
    w_step_nxt   = r_step;
    unique case (r_state)
      StShow: begin
        if (w_accept) begin
          w_state_nxt  = StFadeOut;
          w_target_nxt = w_req_target;
          w_step_nxt   = '0;
        end
      end
      StFadeOut: begin
        if (frame_start) begin
          if (w_step_last) begin
            w_step_nxt  = '0;
            w_level_nxt = r_level - 5'd1;
            // Swap screens while black, on a frame boundary.
            if (r_level == 5'd1) begin
              w_screen_nxt = r_target;
              w_state_nxt  = StFadeIn;
            end
          end else begin
            w_step_nxt = r_step + 1'b1;
          end
        end
      end
      StFadeIn: begin
        if (frame_start) begin
          if (w_step_last) begin
            w_step_nxt  = '0;
            w_level_nxt = r_level + 5'd1;
            if (r_level == LEVEL_MAX - 5'd1) w_state_nxt = StShow;
          end else begin
            w_step_nxt = r_step + 1'b1;
          end
        end
      end
      default: w_state_nxt = StShow;
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= LEVEL_MAX;
      r_step  <= '0;
    end else begin
      r_level <= w_level_nxt;
      r_step  <= w_step_nxt;
    end
  end

  rgb_scaler u_rgb_scaler (
    .i_rgb   (w_sel),
    .i_level (r_level),
    .o_rgb   (w_scaled)
  );
`else
  // StFadeOut doubles as the wait-for-frame_start state.
  always_comb begin
    w_state_nxt  = r_state;
    w_screen_nxt = r_screen;
    w_target_nxt = r_target;
    unique case (r_state)
      StShow: begin
        if (w_accept) begin
          w_state_nxt  = StFadeOut;
          w_target_nxt = w_req_target;
        end
      end
      StFadeOut: begin
        if (frame_start) begin
          w_screen_nxt = r_target;
          w_state_nxt  = StShow;
        end
      end
      default: w_state_nxt = StShow;
    endcase
  end

  assign w_scaled = w_sel;
`endif

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StShow;
      r_screen   <= Start;
      r_target   <= Start;
      r_pix      <= '0;
      r_busy     <= 1'b0;
      r_game_run <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_screen   <= w_screen_nxt;
      r_target   <= w_target_nxt;
      r_pix      <= blank ? rgb12_t'(w_scaled) : '0;
      r_busy     <= (r_state != StShow);
      r_game_run <= (r_state == StShow) && (r_screen == Game);
    end
  end

  assign red      = r_pix.r;
  assign green    = r_pix.g;
  assign blue     = r_pix.b;
  assign screen   = r_screen;
  assign busy     = r_busy;
  assign game_run = r_game_run;

endmodule

// File: tb/tb_screen_fade_sequencer.sv
// Directed self-checking bench for screen_fade_sequencer (STEP_FRAMES=1).
module tb_screen_fade_sequencer;

  logic        vga_clk     = 1'b0;
  logic        reset_n     = 1'b0;
  logic        frame_start = 1'b0;
  logic        start_btn   = 1'b0;
  logic        game_over   = 1'b0;
  logic        blank       = 1'b1;
  logic [11:0] start_rgb   = 12'hF84;
  logic [11:0] game_rgb    = 12'h0A5;
  logic [11:0] over_rgb    = 12'h3C7;
  logic [3:0]  red, green, blue;
  logic [1:0]  screen;
  logic        busy, game_run;

  int errors = 0;
  int checks = 0;

  always #5 vga_clk = ~vga_clk;

  screen_fade_sequencer #(
    .STEP_FRAMES (1)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .start_btn   (start_btn),
    .game_over   (game_over),
    .blank       (blank),
    .start_rgb   (start_rgb),
    .game_rgb    (game_rgb),
    .over_rgb    (over_rgb),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .screen      (screen),
    .busy        (busy),
    .game_run    (game_run)
  );

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pulse_fs(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++; if ({red, green, blue} !== 12'h000)
      begin errors++; $display("FAIL reset_rgb: got %h want 000", {red, green, blue}); end
    checks++; if (screen !== 2'd0)
      begin errors++; $display("FAIL reset_screen: got %0d want 0", screen); end
    checks++; if (busy !== 1'b0 || game_run !== 1'b0)
      begin errors++; $display("FAIL reset_flags: got busy=%b run=%b want 0 0", busy, game_run); end
    reset_n = 1'b1;
    tick();
    checks++; if ({red, green, blue} !== 12'hF84)
      begin errors++; $display("FAIL first_pixel: got %h want F84", {red, green, blue}); end
    checks++; if (screen !== 2'd0 || busy !== 1'b0)
      begin errors++; $display("FAIL first_state: got screen=%0d busy=%b want 0 0", screen, busy); end
  endtask

  task automatic test_blank();
    blank = 1'b0;
    tick();
    checks++; if ({red, green, blue} !== 12'h000)
      begin errors++; $display("FAIL blank_black: got %h want 000", {red, green, blue}); end
    blank = 1'b1;
    tick();
    checks++; if ({red, green, blue} !== 12'hF84)
      begin errors++; $display("FAIL blank_release: got %h want F84", {red, green, blue}); end
  endtask

  task automatic test_ignored_in_start();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || screen !== 2'd0)
      begin errors++; $display("FAIL over_in_start: got busy=%b screen=%0d want 0 0", busy, screen); end
  endtask

`ifdef SCREEN_FADE_EN
  task automatic test_same_cycle_fade();
    start_btn = 1'b1;
    frame_start = 1'b1;
    tick();
    start_btn = 1'b0;
    frame_start = 1'b0;
    tick();
    checks++; if ({red, green, blue} !== 12'hF84)
      begin errors++; $display("FAIL same_cycle_level: got %h want F84", {red, green, blue}); end
    checks++; if (busy !== 1'b1 || screen !== 2'd0)
      begin errors++; $display("FAIL same_cycle_state: got busy=%b screen=%0d want 1 0", busy, screen); end
    pulse_fs(1);
    checks++; if ({red, green, blue} !== 12'hE73)
      begin errors++; $display("FAIL first_step: got %h want E73", {red, green, blue}); end
  endtask

  task automatic test_fade_out();
    pulse_fs(7);
    checks++; if ({red, green, blue} !== 12'h742)
      begin errors++; $display("FAIL level8: got %h want 742", {red, green, blue}); end
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    pulse_fs(7);
    checks++; if (screen !== 2'd0 || {red, green, blue} !== 12'h000)
      begin errors++; $display("FAIL level1: got screen=%0d rgb=%h want 0 000", screen, {red, green, blue}); end
    pulse_fs(1);
    checks++; if (screen !== 2'd1 || {red, green, blue} !== 12'h000)
      begin errors++; $display("FAIL swap_black: got screen=%0d rgb=%h want 1 000", screen, {red, green, blue}); end
    checks++; if (game_run !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("FAIL swap_flags: got run=%b busy=%b want 0 1", game_run, busy); end
  endtask

  task automatic test_fade_in();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    pulse_fs(15);
    checks++; if ({red, green, blue} !== 12'h094 || busy !== 1'b1)
      begin errors++; $display("FAIL level15_in: got rgb=%h busy=%b want 094 1", {red, green, blue}, busy); end
    pulse_fs(1);
    checks++; if (busy !== 1'b0 || game_run !== 1'b1)
      begin errors++; $display("FAIL fade_done: got busy=%b run=%b want 0 1", busy, game_run); end
    checks++; if (screen !== 2'd1 || {red, green, blue} !== 12'h0A5)
      begin errors++; $display("FAIL fade_end_game: got screen=%0d rgb=%h want 1 0A5", screen, {red, green, blue}); end
  endtask

  task automatic test_reset_mid_fade_in();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    pulse_fs(20);
    checks++; if (screen !== 2'd2 || busy !== 1'b1 || {red, green, blue} !== 12'h031)
      begin errors++; $display("FAIL over_level4: got screen=%0d busy=%b rgb=%h want 2 1 031", screen, busy, {red, green, blue}); end
    reset_n = 1'b0;
    #1;
    checks++; if (screen !== 2'd0 || busy !== 1'b0 || {red, green, blue} !== 12'h000)
      begin errors++; $display("FAIL async_reset: got screen=%0d busy=%b rgb=%h want 0 0 000", screen, busy, {red, green, blue}); end
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if ({red, green, blue} !== 12'hF84)
      begin errors++; $display("FAIL reset_level16: got %h want F84", {red, green, blue}); end
  endtask
`else
  task automatic test_switch_nofade();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    checks++; if (busy !== 1'b0)
      begin errors++; $display("FAIL busy_lag: got %b want 0", busy); end
    tick();
    tick();
    checks++; if (busy !== 1'b1 || screen !== 2'd0 || {red, green, blue} !== 12'hF84)
      begin errors++; $display("FAIL waiting: got busy=%b screen=%0d rgb=%h want 1 0 F84", busy, screen, {red, green, blue}); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (screen !== 2'd1 || busy !== 1'b1 || {red, green, blue} !== 12'hF84)
      begin errors++; $display("FAIL cut_edge: got screen=%0d busy=%b rgb=%h want 1 1 F84", screen, busy, {red, green, blue}); end
    tick();
    checks++; if (busy !== 1'b0 || game_run !== 1'b1 || {red, green, blue} !== 12'h0A5)
      begin errors++; $display("FAIL cut_done: got busy=%b run=%b rgb=%h want 0 1 0A5", busy, game_run, {red, green, blue}); end
  endtask

  task automatic test_start_ignored_in_game();
    start_btn = 1'b1;
    tick();
    tick();
    start_btn = 1'b0;
    checks++; if (busy !== 1'b0 || screen !== 2'd1)
      begin errors++; $display("FAIL start_in_game: got busy=%b screen=%0d want 0 1", busy, screen); end
  endtask

  task automatic test_same_cycle_nofade();
    game_over = 1'b1;
    frame_start = 1'b1;
    tick();
    game_over = 1'b0;
    frame_start = 1'b0;
    tick();
    checks++; if (screen !== 2'd1 || busy !== 1'b1 || game_run !== 1'b0)
      begin errors++; $display("FAIL same_cycle: got screen=%0d busy=%b run=%b want 1 1 0", screen, busy, game_run); end
    pulse_fs(1);
    checks++; if (screen !== 2'd2 || busy !== 1'b0 || {red, green, blue} !== 12'h3C7)
      begin errors++; $display("FAIL to_over: got screen=%0d busy=%b rgb=%h want 2 0 3C7", screen, busy, {red, green, blue}); end
  endtask

  task automatic test_reset_mid_nofade();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    tick();
    checks++; if (busy !== 1'b1 || screen !== 2'd2)
      begin errors++; $display("FAIL over_wait: got busy=%b screen=%0d want 1 2", busy, screen); end
    reset_n = 1'b0;
    #1;
    checks++; if (screen !== 2'd0 || busy !== 1'b0 || {red, green, blue} !== 12'h000)
      begin errors++; $display("FAIL async_reset: got screen=%0d busy=%b rgb=%h want 0 0 000", screen, busy, {red, green, blue}); end
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if ({red, green, blue} !== 12'hF84 || busy !== 1'b0)
      begin errors++; $display("FAIL after_reset: got rgb=%h busy=%b want F84 0", {red, green, blue}, busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_blank();
    test_ignored_in_start();
`ifdef SCREEN_FADE_EN
    test_same_cycle_fade();
    test_fade_out();
    test_fade_in();
    test_reset_mid_fade_in();
`else
    test_switch_nofade();
    test_start_ignored_in_game();
    test_same_cycle_nofade();
    test_reset_mid_nofade();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/screen_fade_sequencer.md
# screen_fade_sequencer

Selects which full-screen background (start, gameplay, game-over) drives the VGA pins, and runs frame-synchronous fade-out/fade-in transitions between them. It sits after the per-screen ROM/palette mappers and before the VGA output pins. It takes their 4-bit RGB outputs, scales the selected one by a brightness level, and registers the result. The current screen is exported to game logic.

## Interface
- `STEP_FRAMES`, default 2, number of `frame_start` pulses per brightness step (≥1).
- `vga_clk` in 1: single clock (pixel clock).
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse at start of vertical blank.
- `start_btn` in 1: synchronised level; request to leave the start or game-over screen.
- `game_over` in 1: one-cycle pulse from game logic.
- `blank` in 1: 1 = active display region, 0 = blanking.
- `start_rgb`, `game_rgb`, `over_rgb` in 12 each: {r,g,b} from the three mappers.
- `red`, `green`, `blue` out 4 each: registered pixel output.
- `screen` out 2: current screen. START=0, GAME=1, OVER=2.
- `busy` out 1: high while fading.
- `game_run` out 1: high only in SHOW with `screen`=GAME.

## Operation
- States: SHOW, FADE_OUT, FADE_IN. Registers: `screen`, `target`, `level` (5 bits, 0..16), step counter.
- Reset values: SHOW, `screen`=START, `target`=START, `level`=16, step counter 0, `red`/`green`/`blue`=0, `busy`=0, `game_run`=0.
- Requests are sampled only in SHOW. Requests in any other state are ignored and not queued.
  - START + `start_btn` → `target`=GAME.
  - GAME + `game_over` → `target`=OVER.
  - OVER + `start_btn` → `target`=START.
  - `start_btn` is ignored in GAME. `game_over` is ignored outside GAME.
- On an accepted request: go to FADE_OUT next cycle and clear the step counter. A `frame_start` in the same cycle is not counted.
- Stepping: in FADE_OUT/FADE_IN, each `frame_start` increments the step counter. When it reaches `STEP_FRAMES`-1 on a `frame_start`, the counter clears and `level` steps by 1.
- FADE_OUT: `level` decrements. On the step that makes `level`=0, the same cycle sets `screen`←`target` and moves to FADE_IN.
- FADE_IN: `level` increments. On the step that makes `level`=16, moves to SHOW.
- Full transition takes 32·`STEP_FRAMES` `frame_start` pulses. `screen` changes only on a `frame_start` cycle, so there is no mid-frame tearing.
- Pixel path: select the source by `screen`. Each channel out = (c·`level`)>>4, using a 9-bit product. `level`=16 is identity and `level`=0 is black.
- If `blank`=0, the output is 0 regardless of level.

## Timing
- Pixel path latency: exactly 1 `vga_clk` cycle from inputs (`*_rgb`, `blank`, `level`, `screen`) to `red`/`green`/`blue`.
- `busy` and `game_run` are registered and change in the cycle after the state change.
- `reset_n` low mid-fade forces the reset values immediately (asynchronously). The fade is abandoned.

## Configuration
- `SCREEN_FADE_EN` defined: behaviour as above.
- `SCREEN_FADE_EN` undefined:
  - No scaler. `level` is held at 16.
  - An accepted request sets `screen`←`target` on the next `frame_start` and returns to SHOW. `busy` is high only while waiting for that pulse.
  - The step counter and `STEP_FRAMES` are unused.

## Structure
- Shared package `screen_pkg` holds:
  - `screen_t` enum (START, GAME, OVER).
  - `fade_state_t` enum (SHOW, FADE_OUT, FADE_IN).
  - `LEVEL_MAX`=16.
  - `rgb12_t` packed struct {r,g,b}.
- One sub-module, `rgb_scaler`: combinational, scales a 12-bit colour by a 5-bit level. It is instantiated only under `SCREEN_FADE_EN`.

## Test plan
- Reset release, `start_rgb`=12'hF84, `blank`=1 → next cycle red/green/blue = F/8/4; `screen`=0, `busy`=0.
- `STEP_FRAMES`=1, `start_btn` pulse, then 16 `frame_start` pulses:
  - After 8 pulses, `level`=8 and F/8/4 outputs 7/4/2.
  - After 16 pulses, `screen`=1 and the output is black.
  - After 16 more, `level`=16, `game_run`=1.
- `game_over` during a fade → ignored; the completed fade ends in GAME, not OVER.
- `start_btn` and `frame_start` in the same SHOW cycle → `level` is still 16 after that cycle; the first decrement happens on the next `frame_start`.
- `blank`=0 with `level`=16 and nonzero rgb → output 0 one cycle later.
- `reset_n` asserted mid-FADE_IN in OVER → immediately `screen`=0, `level`=16, outputs 0.
